// File: rtl/noc_link_credit_receiver.sv
`default_nettype none
// ============================================================================
// Module   : noc_link_credit_receiver
// Brief    : Credit-link receiver. It buffers flits, drives them out on a
//            valid/ready interface, returns credits, checks the link
//            protocol and counts delivered packets.
// Revision : 1.0 - initial release
// ============================================================================
module noc_link_credit_receiver #(
    parameter int FLIT_WIDTH      = 64,
    parameter int DEST_WIDTH      = 6,
    parameter int BUFFER_DEPTH    = 4,
    parameter int PKT_COUNT_WIDTH = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [FLIT_WIDTH-1:0]              data_in,
    input  logic [DEST_WIDTH-1:0]              dest_in,
    input  logic                               is_tail_in,
    input  logic                               send_in,
    output logic                               credit_out,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [FLIT_WIDTH-1:0]              out_data,
    output logic [DEST_WIDTH-1:0]              out_dest,
    output logic                               out_is_tail,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]  occupancy,
    output logic                               overflow_err,
    output logic                               dest_mismatch_err,
    output logic [PKT_COUNT_WIDTH-1:0]         pkt_count
);

    localparam int c_PTR_W   = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(BUFFER_DEPTH + 1);
    localparam int c_ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(BUFFER_DEPTH);

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_BODY = 1'b1
    } rx_state_t;

    logic [c_ENTRY_W-1:0]       r_mem [BUFFER_DEPTH];
    logic [c_PTR_W-1:0]         r_wr_ptr;
    logic [c_PTR_W-1:0]         r_rd_ptr;
    logic [c_CNT_W-1:0]         r_count;
    logic                       r_credit;
    logic                       r_ovf_err;
    logic                       r_dest_err;
    logic [PKT_COUNT_WIDTH-1:0] r_pkt_cnt;
    logic [DEST_WIDTH-1:0]      r_head_dest;
    rx_state_t                  r_state;

    logic                       w_deq;
    logic                       w_enq;
    logic                       w_drop;
    logic [c_ENTRY_W-1:0]       w_head;

    assign w_head = r_mem[r_rd_ptr];
    assign w_deq  = (r_count != '0) & out_ready;
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign w_enq  = send_in & ((r_count != c_DEPTH) | w_deq);
    assign w_drop = send_in & ~w_enq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUFFER_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= {is_tail_in, dest_in, data_in};
                r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + c_PTR_W'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit  <= 1'b0;
            r_ovf_err <= 1'b0;
            r_pkt_cnt <= '0;
        end else begin
            r_credit <= w_deq;
            if (w_drop) begin
                r_ovf_err <= 1'b1;
            end
            if (w_deq && w_head[c_ENTRY_W-1]) begin
                r_pkt_cnt <= r_pkt_cnt + PKT_COUNT_WIDTH'(1);
            end
        end
    end

    // Packet tracking only advances on flits that were actually stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RX_IDLE;
            r_head_dest <= '0;
            r_dest_err  <= 1'b0;
        end else if (w_enq) begin
            case (r_state)
                RX_IDLE: begin
                    if (!is_tail_in) begin
                        r_head_dest <= dest_in;
                        r_state     <= RX_BODY;
                    end
                end
                RX_BODY: begin
                    if (dest_in != r_head_dest) begin
                        r_dest_err <= 1'b1;
                    end
                    if (is_tail_in) begin
                        r_state <= RX_IDLE;
                    end
                end
                default: r_state <= RX_IDLE;
            endcase
        end
    end

    assign out_valid         = (r_count != '0);
    assign out_data          = w_head[FLIT_WIDTH-1:0];
    assign out_dest          = w_head[FLIT_WIDTH +: DEST_WIDTH];
    assign out_is_tail       = w_head[c_ENTRY_W-1];
    assign occupancy         = r_count;
    assign credit_out        = r_credit;
    assign overflow_err      = r_ovf_err;
    assign dest_mismatch_err = r_dest_err;
    assign pkt_count         = r_pkt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_noc_link_credit_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_link_credit_receiver
// Brief    : Directed self-checking bench for noc_link_credit_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_link_credit_receiver;

    localparam int FW = 64;
    localparam int DW = 6;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] data_in = '0;
    logic [DW-1:0] dest_in = '0;
    logic          is_tail_in = 1'b0;
    logic          send_in = 1'b0;
    logic          out_ready = 1'b0;
    logic          credit_out;
    logic          out_valid;
    logic [FW-1:0] out_data;
    logic [DW-1:0] out_dest;
    logic          out_is_tail;
    logic [2:0]    occupancy;
    logic          overflow_err;
    logic          dest_mismatch_err;
    logic [PW-1:0] pkt_count;

    int n_total = 0;
    int n_bad   = 0;

    noc_link_credit_receiver #(
        .FLIT_WIDTH      (FW),
        .DEST_WIDTH      (DW),
        .BUFFER_DEPTH    (4),
        .PKT_COUNT_WIDTH (PW)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .data_in           (data_in),
        .dest_in           (dest_in),
        .is_tail_in        (is_tail_in),
        .send_in           (send_in),
        .credit_out        (credit_out),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_data          (out_data),
        .out_dest          (out_dest),
        .out_is_tail       (out_is_tail),
        .occupancy         (occupancy),
        .overflow_err      (overflow_err),
        .dest_mismatch_err (dest_mismatch_err),
        .pkt_count         (pkt_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic [FW-1:0] d, input logic [DW-1:0] dst, input logic t);
        send_in    = s;
        data_in    = d;
        dest_in    = dst;
        is_tail_in = t;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1 rst = 1'b0;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_dest", out_dest, 0);
        chk("rst_tail", out_is_tail, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_credit", credit_out, 0);
        chk("rst_errs", {overflow_err, dest_mismatch_err}, 0);
        chk("rst_pkt", pkt_count, 0);
        rst = 1'b0;
        tick();

        // Single-flit packet
        out_ready = 1'b1;
        drive(1, 64'hA5, 6'h05, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 64'hA5);
        chk("single_dest", out_dest, 6'h05);
        chk("single_credit_early", credit_out, 0);
        tick();
        chk("single_credit", credit_out, 1);
        chk("single_pkt", pkt_count, 1);
        chk("single_empty", out_valid, 0);
        tick();
        chk("single_credit_off", credit_out, 0);

        // Fill, overflow, backpressure, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drive(1, 64'(i), 0, 1);
            tick();
        end
        chk("fill_occ", occupancy, 4);
        chk("fill_ovf_clear", overflow_err, 0);
        drive(1, 64'h5, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("ovf_flag", overflow_err, 1);
        chk("ovf_occ", occupancy, 4);
        chk("hold_data", out_data, 1);
        tick();
        chk("hold_stable", out_data, 1);
        out_ready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("drain_data", out_data, 64'(i));
            chk("drain_credit", credit_out, 1);
        end
        tick();
        chk("drain_credit4", credit_out, 1);
        chk("drain_empty", out_valid, 0);
        chk("drain_occ", occupancy, 0);
        chk("drain_pkt", pkt_count, 5);
        tick();
        chk("drain_credit_off", credit_out, 0);
        chk("ovf_sticky", overflow_err, 1);

        // Asynchronous reset with three flits stored
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 64'h30 + 64'(i), 0, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("pre_rst_occ", occupancy, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_occ", occupancy, 0);
        chk("async_valid", out_valid, 0);
        chk("async_ovf", overflow_err, 0);
        chk("async_pkt", pkt_count, 0);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_credit", credit_out, 0);
        end

        // Full with simultaneous drain
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h10 + 64'(i), 0, 1);
            tick();
        end
        chk("full_occ", occupancy, 4);
        out_ready = 1'b1;
        drive(1, 64'h14, 0, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("simul_occ", occupancy, 4);
        chk("simul_ovf", overflow_err, 0);
        chk("simul_head", out_data, 64'h11);
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("simul_order", out_data, 64'h10 + 64'(i));
        end
        tick();
        chk("simul_empty", out_valid, 0);
        chk("simul_pkt", pkt_count, 5);

        // Dest mismatch inside a packet
        drive(1, 64'h21, 6'h03, 0);
        tick();
        chk("mm_head_data", out_data, 64'h21);
        chk("mm_head_tail", out_is_tail, 0);
        chk("mm_no_err_yet", dest_mismatch_err, 0);
        drive(1, 64'h22, 6'h07, 0);
        tick();
        chk("mm_body_data", out_data, 64'h22);
        chk("mm_body_dest", out_dest, 6'h07);
        chk("mm_err", dest_mismatch_err, 1);
        drive(1, 64'h23, 6'h03, 1);
        tick();
        drive(0, 0, 0, 0);
        chk("mm_tail_data", out_data, 64'h23);
        chk("mm_tail_flag", out_is_tail, 1);
        tick();
        chk("mm_pkt", pkt_count, 6);
        chk("mm_sticky", dest_mismatch_err, 1);

        // Consistent multi-flit packet raises no error
        do_reset();
        chk("clean_rst_err", dest_mismatch_err, 0);
        drive(1, 64'h41, 6'h09, 0);
        tick();
        drive(1, 64'h42, 6'h09, 0);
        tick();
        drive(1, 64'h43, 6'h09, 1);
        tick();
        drive(1, 64'h44, 6'h02, 1);
        tick();
        drive(0, 0, 0, 0);
        tick();
        chk("clean_err", dest_mismatch_err, 0);
        chk("clean_pkt", pkt_count, 2);

        // Counter wrap: 17 packets from zero
        do_reset();
        chk("wrap_start", pkt_count, 0);
        for (int i = 0; i < 17; i++) begin
            drive(1, 64'h100 + 64'(i), 6'h01, 1);
            tick();
        end
        drive(0, 0, 0, 0);
        chk("wrap_credit", credit_out, 1);
        tick();
        chk("wrap_pkt", pkt_count, 1);
        tick();
        chk("wrap_credit_off", credit_out, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
